// File: rtl/fetch_pkg.sv
// Shared fetch-sequencer types and constants, also used by next-PC logic and decode.
package fetch_pkg;

  localparam int unsigned PcWidth    = 64;
  localparam int unsigned InstrWidth = 32;

  // Any set bit under this mask in a committed PC marks it misaligned.
  localparam logic [1:0] AlignMask = 2'b11;

  typedef enum logic [1:0] {
    StReq   = 2'd0,
    StWait  = 2'd1,
    StValid = 2'd2,
    StFault = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/retire_counter.sv
// Wrap-around counter with synchronous clear (priority) and count enable.
module retire_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer: issues one fetch per instruction, holds it for
// decode until execute accepts, then commits the externally computed next PC.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = PcWidth,
  parameter int unsigned INSTR_WIDTH = InstrWidth,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic [PC_WIDTH-1:0]    StartPC,
  input  logic [PC_WIDTH-1:0]    NextPC,
  input  logic                   InstrAccept,
  output logic                   IMemReqValid,
  input  logic                   IMemReqReady,
  output logic [PC_WIDTH-1:0]    IMemAddr,
  input  logic                   IMemRespValid,
  input  logic [INSTR_WIDTH-1:0] IMemRespData,
  output logic [PC_WIDTH-1:0]    CurrentPC,
  output logic [INSTR_WIDTH-1:0] Instruction,
  output logic                   InstrValid,
  output logic                   Fault,
  output logic [CNT_WIDTH-1:0]   RetireCount
);

  fetch_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   retire;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= StReq;
      pc_q    <= StartPC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    retire  = 1'b0;
    unique case (state_q)
      // Responses seen here predate the last reset and are dropped.
      StReq: begin
        if (IMemReqReady) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (IMemRespValid) begin
          instr_d = IMemRespData;
          state_d = StValid;
        end
      end
      StValid: begin
        if (InstrAccept) begin
          pc_d    = NextPC;
          retire  = 1'b1;
          state_d = ((NextPC[1:0] & AlignMask) != 2'b00) ? StFault : StReq;
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StReq;
      end
    endcase
  end

  always_comb begin
    IMemReqValid = (state_q == StReq);
    InstrValid   = (state_q == StValid);
    Fault        = (state_q == StFault);
    IMemAddr     = pc_q;
    CurrentPC    = pc_q;
    Instruction  = instr_q;
  end

  retire_counter #(
    .Width (CNT_WIDTH)
  ) u_retire_counter (
    .clk_i   (CLK),
    .clr_i   (Reset),
    .en_i    (retire),
    .count_o (RetireCount)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: per-cycle vector table plus a scoreboarded 16-instruction run.
module tb_pc_fetch_unit;

  localparam int unsigned PW = 64;
  localparam int unsigned IW = 32;
  localparam int unsigned CW = 4;

  logic          CLK = 1'b0;
  logic          Reset;
  logic [PW-1:0] StartPC;
  logic [PW-1:0] NextPC;
  logic          InstrAccept;
  logic          IMemReqValid;
  logic          IMemReqReady;
  logic [PW-1:0] IMemAddr;
  logic          IMemRespValid;
  logic [IW-1:0] IMemRespData;
  logic [PW-1:0] CurrentPC;
  logic [IW-1:0] Instruction;
  logic          InstrValid;
  logic          Fault;
  logic [CW-1:0] RetireCount;

  pc_fetch_unit #(
    .PC_WIDTH    (PW),
    .INSTR_WIDTH (IW),
    .CNT_WIDTH   (CW)
  ) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .StartPC       (StartPC),
    .NextPC        (NextPC),
    .InstrAccept   (InstrAccept),
    .IMemReqValid  (IMemReqValid),
    .IMemReqReady  (IMemReqReady),
    .IMemAddr      (IMemAddr),
    .IMemRespValid (IMemRespValid),
    .IMemRespData  (IMemRespData),
    .CurrentPC     (CurrentPC),
    .Instruction   (Instruction),
    .InstrValid    (InstrValid),
    .Fault         (Fault),
    .RetireCount   (RetireCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          rst;
    logic          ready;
    logic          rv;
    logic [IW-1:0] data;
    logic          acc;
    logic [PW-1:0] npc;
    logic          e_reqv;
    logic [PW-1:0] e_addr;
    logic          e_iv;
    logic [IW-1:0] e_instr;
    logic          e_fault;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t          tv[$];
  logic [IW-1:0] sb[$];
  int            total = 0;
  int            bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic ready, input logic rv, input logic [IW-1:0] data,
                     input logic acc, input logic [PW-1:0] npc, input logic reqv,
                     input logic [PW-1:0] addr, input logic iv, input logic [IW-1:0] instr,
                     input logic fault, input logic [CW-1:0] cnt);
    vec_t v;
    v.rst = rst; v.ready = ready; v.rv = rv; v.data = data; v.acc = acc; v.npc = npc;
    v.e_reqv = reqv; v.e_addr = addr; v.e_iv = iv; v.e_instr = instr;
    v.e_fault = fault; v.e_cnt = cnt;
    tv.push_back(v);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic rst, input logic ready, input logic rv,
                       input logic [IW-1:0] data, input logic acc, input logic [PW-1:0] npc);
    Reset = rst; IMemReqReady = ready; IMemRespValid = rv; IMemRespData = data;
    InstrAccept = acc; NextPC = npc;
  endtask

  localparam logic [IW-1:0] I0 = 32'hF840_03E9;
  localparam logic [IW-1:0] IA = 32'h8B01_0000;
  localparam logic [IW-1:0] IB = 32'hD65F_03C0;

  initial begin
    StartPC = 64'h1000;
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);

    //  rst rdy rv data          acc npc     | reqv addr     iv instr         flt cnt
    add(1, 1, 0, 0,            0, 0,        1, 64'h1000, 0, 0,            0, 0);
    add(0, 1, 0, 0,            0, 0,        0, 64'h1000, 0, 0,            0, 0);
    add(0, 0, 1, I0,           0, 0,        0, 64'h1000, 1, I0,           0, 0);
    add(0, 0, 0, 0,            1, 64'h1004, 1, 64'h1004, 0, I0,           0, 1);
    add(0, 0, 0, 0,            0, 0,        1, 64'h1004, 0, I0,           0, 1);
    add(0, 0, 0, 0,            0, 0,        1, 64'h1004, 0, I0,           0, 1);
    add(0, 0, 0, 0,            0, 0,        1, 64'h1004, 0, I0,           0, 1);
    add(0, 1, 0, 0,            0, 0,        0, 64'h1004, 0, I0,           0, 1);
    add(0, 0, 1, IA,           0, 0,        0, 64'h1004, 1, IA,           0, 1);
    add(0, 0, 0, 0,            1, 64'h0FF8, 1, 64'h0FF8, 0, IA,           0, 2);
    add(0, 1, 0, 0,            0, 0,        0, 64'h0FF8, 0, IA,           0, 2);
    add(0, 0, 1, IB,           0, 0,        0, 64'h0FF8, 1, IB,           0, 2);
    add(0, 1, 0, 0,            1, 64'h1006, 0, 64'h1006, 0, IB,           1, 3);
    add(0, 1, 1, IA,           1, 64'h2000, 0, 64'h1006, 0, IB,           1, 3);
    add(1, 0, 0, 0,            0, 0,        1, 64'h1000, 0, 0,            0, 0);
    add(0, 1, 0, 0,            0, 0,        0, 64'h1000, 0, 0,            0, 0);
    add(1, 0, 0, 0,            0, 0,        1, 64'h1000, 0, 0,            0, 0);
    add(0, 0, 1, 32'hDEADBEEF, 0, 0,        1, 64'h1000, 0, 0,            0, 0);
    add(0, 1, 1, 32'hDEADBEEF, 0, 0,        0, 64'h1000, 0, 0,            0, 0);
    add(0, 0, 0, 0,            0, 0,        0, 64'h1000, 0, 0,            0, 0);
    add(0, 0, 1, 32'h12345678, 0, 0,        0, 64'h1000, 1, 32'h12345678, 0, 0);
    add(0, 0, 0, 0,            1, 64'h2000, 1, 64'h2000, 0, 32'h12345678, 0, 1);
    add(0, 1, 0, 0,            0, 0,        0, 64'h2000, 0, 32'h12345678, 0, 1);
    add(0, 0, 1, 32'h11111111, 0, 0,        0, 64'h2000, 1, 32'h11111111, 0, 1);
    add(1, 0, 0, 0,            1, 64'h3000, 1, 64'h1000, 0, 0,            0, 0);
    add(0, 0, 0, 0,            1, 64'h3000, 1, 64'h1000, 0, 0,            0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rst, tv[i].ready, tv[i].rv, tv[i].data, tv[i].acc, tv[i].npc);
      tick();
      chk($sformatf("v%0d.reqv", i),  64'(IMemReqValid), 64'(tv[i].e_reqv));
      chk($sformatf("v%0d.addr", i),  IMemAddr,          tv[i].e_addr);
      chk($sformatf("v%0d.pc", i),    CurrentPC,         tv[i].e_addr);
      chk($sformatf("v%0d.iv", i),    64'(InstrValid),   64'(tv[i].e_iv));
      chk($sformatf("v%0d.instr", i), 64'(Instruction),  64'(tv[i].e_instr));
      chk($sformatf("v%0d.fault", i), 64'(Fault),        64'(tv[i].e_fault));
      chk($sformatf("v%0d.cnt", i),   64'(RetireCount),  64'(tv[i].e_cnt));
    end

    // Sixteen back-to-back instructions: the 4-bit retire count must wrap to zero.
    for (int i = 0; i < 16; i++) begin
      logic [PW-1:0] pc;
      logic [IW-1:0] d;
      int            n;
      pc = 64'h1000 + 64'(4 * i);
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      n = 0;
      while (!IMemReqValid && n < 20) begin
        tick();
        n++;
      end
      chk($sformatf("w%0d.reqv", i), 64'(IMemReqValid), 64'd1);
      chk($sformatf("w%0d.addr", i), IMemAddr, pc);
      IMemReqReady = 1'b1;
      tick();
      d = $urandom;
      sb.push_back(d);
      drive(1'b0, 1'b0, 1'b1, d, 1'b0, '0);
      tick();
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      n = 0;
      while (!InstrValid && n < 20) begin
        tick();
        n++;
      end
      chk($sformatf("w%0d.iv", i), 64'(InstrValid), 64'd1);
      if (sb.size() > 0) begin
        chk($sformatf("w%0d.instr", i), 64'(Instruction), 64'(sb.pop_front()));
      end
      drive(1'b0, 1'b0, 1'b0, '0, 1'b1, pc + 64'd4);
      tick();
      chk($sformatf("w%0d.cnt", i), 64'(RetireCount), 64'((i + 1) % 16));
      chk($sformatf("w%0d.pc", i), CurrentPC, pc + 64'd4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
